sobel_stream: RTL and testbench
===============================

// Module: sobel_stream
// PURPOSE
//   Streaming 3x3 Sobel edge filter for grayscale frames of IMG_W x IMG_H pixels.
//   Pops one pixel per FIFO read in raster order (row 0 = bottom bmp row, x ascending)
//   and pushes exactly one edge-magnitude pixel per input pixel to the output FIFO.
//   Sits between the grayscale stage FIFO and the output/bmp-writer FIFO.
//   Owns its own line buffers, border handling, end-of-frame flush and backpressure.
// PARAMETERS
//   DWIDTH_IN   8    grayscale input pixel width
//   DWIDTH_OUT  8    output pixel width; magnitude saturates to 2^DWIDTH_OUT-1
//   IMG_W       720  pixels per row (>=3)
//   IMG_H       540  rows per frame (>=3)
//   MAG_MODE    0    0: |Gx|+|Gy|   1: max(|Gx|,|Gy|)
//   THRESHOLD   0    0: raw saturated magnitude; >0: output all-ones if mag>=THRESHOLD, else 0
// PORTS
//   clock           in   1           rising-edge clock
//   reset           in   1           synchronous, active-high
//   fifo_in_rd_en   out  1           pop request; pixel on fifo_in_dout consumed same edge
//   fifo_in_dout    in   DWIDTH_IN   input pixel (first-word-fall-through)
//   fifo_in_empty   in   1           input FIFO empty
//   fifo_out_wr_en  out  1           push request
//   fifo_out_din    out  DWIDTH_OUT  output pixel
//   fifo_out_full   in   1           output FIFO full
// BEHAVIOUR
//   Reset: fifo_in_rd_en=0, fifo_out_wr_en=0, fifo_out_din=0, state=S_FILL, all counters 0.
//     Line-buffer RAM not cleared. Reset mid-frame abandons the frame; next pixel read is (0,0).
//   Output register: out_valid/out_data; fifo_out_wr_en=out_valid, fifo_out_din=out_data.
//   advance = !out_valid || !fifo_out_full. Window, line buffers and counters move only on advance.
//   fifo_in_rd_en = !fifo_in_empty && advance && state!=S_FLUSH (combinational).
//   Window w[r][c]: r=0 row y-1, r=2 row y+1; c=0 column x-1. Centre w[1][1] = pixel (x,y).
//   Gx=(w02+2w12+w22)-(w00+2w10+w20); Gy=(w20+2w21+w22)-(w00+2w01+w02);
//     signed DWIDTH_IN+3 bits; magnitude unsigned DWIDTH_IN+3 bits before clamp/threshold.
//   Border: output pixel (ox,oy) with ox in {0,IMG_W-1} or oy in {0,IMG_H-1} is 0 (also in
//     THRESHOLD mode). Window columns wrap across rows; border masking hides the wrap.
//   Latency: output k issues on the advance edge that reads input k+IMG_W+1; out_valid next cycle.
//   States:
//     S_FILL : read first IMG_W+1 pixels, no outputs; -> S_RUN on the (IMG_W+1)th read.
//     S_RUN  : each read produces one output; after read of pixel IMG_W*IMG_H-1 -> S_FLUSH.
//     S_FLUSH: no reads; emit IMG_W+1 zero (border) outputs, one per advance; then -> S_FILL.
//   Input empty in S_FILL/S_RUN: hold, no output generated (out_valid drains normally).
//   Simultaneous full+empty: nothing moves. Output held stable while full && out_valid.
//   Back-to-back frames: next frame's reads start the cycle after the last flush output issues.
//   Counters: in_x/in_y wrap at IMG_W/IMG_H; out_x/out_y wrap identically; clog2 widths.
// STRUCTURE
//   Shared header sobel_defs.vh: state encodings S_FILL/S_RUN/S_FLUSH, MAG_SUM/MAG_MAX
//     mode constants, Sobel kernel coefficients.
//   Sub-module line_buffer (DWIDTH_IN x IMG_W, read-before-write, enable=advance&&read);
//     instantiate twice, cascaded, feeding window columns r=1 and r=0.
//   Top: FSM, counters, 3x3 window, Gx/Gy/magnitude, clamp/threshold, output register.
// TESTING  (IMG_W=8, IMG_H=6, widths 8, unless noted)
//   Constant 100 frame -> 48 outputs, all 0; rd_en count 48; state back to S_FILL.
//   Vertical step: cols 0-3 =0, cols 4-7 =255 -> rows 1-4 cols 3,4 = 255 (1020 clamped), rest 0.
//   Ramp pix=10*x -> interior outputs 80, border 0; MAG_MODE=1 -> interior 80; THRESHOLD=100 -> all 0.
//   Backpressure: fifo_out_full held 20 cycles mid-frame plus random toggling ->
//     no drop/duplicate; fifo_out_din stable while full; stream equals unstalled golden model.
//   Input starvation: random fifo_in_empty gaps incl. during S_FILL -> identical 48-pixel output.
//   Reset after 20 pixels read, then two full frames back-to-back -> exactly 96 outputs, both correct.

Source files
------------

// File: rtl/sobel_stream_pkg.sv
// Shared definitions for the streaming Sobel edge filter.
//   state_t          : frame sequencing states (fill line buffers, run, flush tail)
//   MAG_SUM/MAG_MAX  : magnitude combination modes selected by MAG_MODE
package sobel_stream_pkg;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  localparam int MAG_SUM = 0;  // |Gx| + |Gy|
  localparam int MAG_MAX = 1;  // max(|Gx|, |Gy|)

endpackage

// File: rtl/sobel_stream_line_buffer.sv
// One image row of pixel storage, read-before-write at the same address.
//   clock  : rising-edge clock
//   enable : write din at addr (the old contents appear on dout beforehand)
//   addr   : column index
//   din    : pixel entering the row store
//   dout   : pixel stored at addr one row earlier (combinational read)
module sobel_stream_line_buffer #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 720,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              enable,
  input  logic [AW-1:0]     addr,
  input  logic [DWIDTH-1:0] din,
  output logic [DWIDTH-1:0] dout
);

  logic [DWIDTH-1:0] mem [DEPTH];

  assign dout = mem[addr];

  // NOTE: the row store has no reset; stale contents only ever reach border
  // outputs, which are forced to zero. Non-blocking assignment keeps the
  // combinational read returning the previous row's pixel this cycle.
  always_ff @(posedge clock) begin
    if (enable) mem[addr] <= din;
  end

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge filter, one output pixel per input pixel.
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   fifo_in_rd_en  : pop from the FWFT grayscale FIFO (data consumed same edge)
//   fifo_in_dout   : current head pixel of the input FIFO
//   fifo_in_empty  : input FIFO empty
//   fifo_out_wr_en : push to the output FIFO
//   fifo_out_din   : edge-magnitude pixel being pushed
//   fifo_out_full  : output FIFO full
// Two cascaded line buffers supply the rows above the incoming pixel; the
// incoming pixel plus the two buffered rows form the newest window column, so
// output k is computed on the same edge that reads pixel k+IMG_W+1.
module sobel_stream
  import sobel_stream_pkg::*;
#(
  parameter int DWIDTH_IN  = 8,
  parameter int DWIDTH_OUT = 8,
  parameter int IMG_W      = 720,
  parameter int IMG_H      = 540,
  parameter int MAG_MODE   = 0,
  parameter int THRESHOLD  = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  fifo_in_rd_en,
  input  logic [DWIDTH_IN-1:0]  fifo_in_dout,
  input  logic                  fifo_in_empty,
  output logic                  fifo_out_wr_en,
  output logic [DWIDTH_OUT-1:0] fifo_out_din,
  input  logic                  fifo_out_full
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int MW = DWIDTH_IN + 3;  // holds 8*(2^DWIDTH_IN-1) without overflow
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [31:0]   THR_U  = 32'(THRESHOLD);

  state_t state, state_next;

  logic [XW-1:0] in_x, out_x;
  logic [YW-1:0] in_y, out_y;

  logic                  out_valid;
  logic [DWIDTH_OUT-1:0] out_data;
  logic [DWIDTH_OUT-1:0] pix_next;

  logic advance, rd, issue;

  // Window columns: col_a = x-1, col_b = x, col_new = x+1; index 0 = row y-1.
  logic [DWIDTH_IN-1:0] col_a   [3];
  logic [DWIDTH_IN-1:0] col_b   [3];
  logic [DWIDTH_IN-1:0] col_new [3];
  logic [DWIDTH_IN-1:0] lb_near_dout, lb_far_dout;

  logic signed [MW-1:0] gx, gy;
  logic [MW-1:0]        ax, ay, mag;
  logic                 border;

  assign advance        = !out_valid || !fifo_out_full;
  assign rd             = !reset && !fifo_in_empty && advance && (state != S_FLUSH);
  assign fifo_in_rd_en  = rd;
  assign fifo_out_wr_en = out_valid;
  assign fifo_out_din   = out_data;

  // Near buffer yields row y (one row back), far buffer row y-1 (two back).
  sobel_stream_line_buffer #(.DWIDTH(DWIDTH_IN), .DEPTH(IMG_W)) u_lb_near (
    .clock  (clock),
    .enable (rd),
    .addr   (in_x),
    .din    (fifo_in_dout),
    .dout   (lb_near_dout)
  );

  sobel_stream_line_buffer #(.DWIDTH(DWIDTH_IN), .DEPTH(IMG_W)) u_lb_far (
    .clock  (clock),
    .enable (rd),
    .addr   (in_x),
    .din    (lb_near_dout),
    .dout   (lb_far_dout)
  );

  assign col_new[0] = lb_far_dout;
  assign col_new[1] = lb_near_dout;
  assign col_new[2] = fifo_in_dout;

  // Weighted 1-2-1 tap sum along one kernel edge.
  function automatic logic [MW-1:0] tap_sum(input logic [DWIDTH_IN-1:0] a,
                                            input logic [DWIDTH_IN-1:0] b,
                                            input logic [DWIDTH_IN-1:0] c);
    return MW'(a) + (MW'(b) << 1) + MW'(c);
  endfunction

  // Issue happens on a read in S_RUN, or on any advance while flushing.
  always_comb begin
    // NOTE: every output of this block is assigned first so no path leaves a
    // value held, which would infer a latch.
    state_next = state;
    issue      = advance && ((state == S_RUN && rd) || state == S_FLUSH);
    case (state)
      S_FILL:  if (rd && in_x == '0 && in_y == YW'(1)) state_next = S_RUN;
      S_RUN:   if (rd && in_x == X_LAST && in_y == Y_LAST) state_next = S_FLUSH;
      S_FLUSH: if (issue && out_x == X_LAST && out_y == Y_LAST) state_next = S_FILL;
      default: state_next = S_FILL;
    endcase
  end

  always_comb begin
    gx = tap_sum(col_new[0], col_new[1], col_new[2]) - tap_sum(col_a[0], col_a[1], col_a[2]);
    gy = tap_sum(col_a[2], col_b[2], col_new[2]) - tap_sum(col_a[0], col_b[0], col_new[0]);
    ax = gx[MW-1] ? -gx : gx;
    ay = gy[MW-1] ? -gy : gy;
    if (MAG_MODE == MAG_MAX) mag = (ax > ay) ? ax : ay;
    else                     mag = ax + ay;

    if (THRESHOLD > 0)
      pix_next = (32'(mag) >= THR_U) ? '1 : '0;
    else if (DWIDTH_OUT < MW && mag > MW'((1 << DWIDTH_OUT) - 1))
      pix_next = '1;
    else
      pix_next = DWIDTH_OUT'(mag);

    // Border masking also hides the column wrap between rows and the flush tail.
    border = (out_x == '0) || (out_x == X_LAST) || (out_y == '0) || (out_y == Y_LAST);
    if (border || state == S_FLUSH) pix_next = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_FILL;
      in_x      <= '0;
      in_y      <= '0;
      out_x     <= '0;
      out_y     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state <= state_next;
      if (rd) begin
        if (in_x == X_LAST) begin
          in_x <= '0;
          in_y <= (in_y == Y_LAST) ? '0 : in_y + 1'b1;
        end else begin
          in_x <= in_x + 1'b1;
        end
      end
      if (issue) begin
        if (out_x == X_LAST) begin
          out_x <= '0;
          out_y <= (out_y == Y_LAST) ? '0 : out_y + 1'b1;
        end else begin
          out_x <= out_x + 1'b1;
        end
      end
      // A full FIFO with pending data freezes the output register.
      if (advance) begin
        out_valid <= issue;
        if (issue) out_data <= pix_next;
      end
    end
  end

  // Window shift register; pure datapath, so it is left without reset.
  always_ff @(posedge clock) begin
    if (rd) begin
      for (int r = 0; r < 3; r++) begin
        col_a[r] <= col_b[r];
        col_b[r] <= col_new[r];
      end
    end
  end

endmodule

// File: tb/tb_sobel_stream.sv
// Directed bench for sobel_stream on an 8x6 frame. Three instances share the
// same FIFO handshakes (sum mode, max mode, threshold 100); their handshakes
// must stay identical since mode does not affect timing.
module tb_sobel_stream;
  import sobel_stream_pkg::*;

  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       fifo_in_empty = 1'b1;
  logic [7:0] fifo_in_dout  = 8'h00;
  logic       fifo_out_full = 1'b0;
  logic       rd_a, rd_b, rd_c, wr_a, wr_b, wr_c;
  logic [7:0] din_a, din_b, din_c;

  always #5 clock = ~clock;

  sobel_stream #(.DWIDTH_IN(8), .DWIDTH_OUT(8), .IMG_W(W), .IMG_H(H),
                 .MAG_MODE(0), .THRESHOLD(0)) dut_a (
    .clock(clock), .reset(reset),
    .fifo_in_rd_en(rd_a), .fifo_in_dout(fifo_in_dout), .fifo_in_empty(fifo_in_empty),
    .fifo_out_wr_en(wr_a), .fifo_out_din(din_a), .fifo_out_full(fifo_out_full));

  sobel_stream #(.DWIDTH_IN(8), .DWIDTH_OUT(8), .IMG_W(W), .IMG_H(H),
                 .MAG_MODE(1), .THRESHOLD(0)) dut_b (
    .clock(clock), .reset(reset),
    .fifo_in_rd_en(rd_b), .fifo_in_dout(fifo_in_dout), .fifo_in_empty(fifo_in_empty),
    .fifo_out_wr_en(wr_b), .fifo_out_din(din_b), .fifo_out_full(fifo_out_full));

  sobel_stream #(.DWIDTH_IN(8), .DWIDTH_OUT(8), .IMG_W(W), .IMG_H(H),
                 .MAG_MODE(0), .THRESHOLD(100)) dut_c (
    .clock(clock), .reset(reset),
    .fifo_in_rd_en(rd_c), .fifo_in_dout(fifo_in_dout), .fifo_in_empty(fifo_in_empty),
    .fifo_out_wr_en(wr_c), .fifo_out_din(din_c), .fifo_out_full(fifo_out_full));

  int checks = 0;
  int failures = 0;
  int rd_count = 0;
  int gap_pct = 0;
  int full_pct = 0;
  int hold_left = 0;
  int hold_violations = 0;
  int sync_err = 0;
  logic held_prev = 1'b0;
  logic [7:0] din_prev = 8'h00;

  logic [7:0] src_q [$];
  logic [7:0] q_a [$];
  logic [7:0] q_b [$];
  logic [7:0] q_c [$];
  int frames [2][N];

  // ---------------------------------------------------------------- helpers
  function automatic int px(input int f, input int x, input int y);
    return frames[f][y * W + x];
  endfunction

  // Direct 2-D reference of one output pixel.
  function automatic logic [7:0] model(input int f, input int x, input int y,
                                       input int mode, input int thr);
    int gx, gy, ax, ay, mag;
    if (x == 0 || x == W - 1 || y == 0 || y == H - 1) return 8'd0;
    gx = px(f, x+1, y-1) + 2*px(f, x+1, y) + px(f, x+1, y+1)
       - px(f, x-1, y-1) - 2*px(f, x-1, y) - px(f, x-1, y+1);
    gy = px(f, x-1, y+1) + 2*px(f, x, y+1) + px(f, x+1, y+1)
       - px(f, x-1, y-1) - 2*px(f, x, y-1) - px(f, x+1, y-1);
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    mag = (mode == 1) ? ((ax > ay) ? ax : ay) : ax + ay;
    if (thr > 0) return (mag >= thr) ? 8'd255 : 8'd0;
    return (mag > 255) ? 8'd255 : 8'(mag);
  endfunction

  task automatic fill_frame(input int f, input int kind);
    for (int i = 0; i < N; i++) begin
      int x = i % W;
      case (kind)
        0:       frames[f][i] = 100;
        1:       frames[f][i] = (x >= 4) ? 255 : 0;
        2:       frames[f][i] = 10 * x;
        default: frames[f][i] = int'($urandom_range(255));
      endcase
    end
  endtask

  task automatic load_frame(input int f);
    for (int i = 0; i < N; i++) src_q.push_back(8'(frames[f][i]));
  endtask

  task automatic drive_inputs();
    fifo_in_empty = (src_q.size() == 0) || (int'($urandom_range(99)) < gap_pct);
    fifo_in_dout  = (src_q.size() > 0) ? src_q[0] : 8'h00;
    if (hold_left > 0) begin
      fifo_out_full = 1'b1;
      hold_left--;
    end else begin
      fifo_out_full = int'($urandom_range(99)) < full_pct;
    end
  endtask

  // One clock: observe at the falling edge, update FIFO models after the rise.
  task automatic step();
    logic do_pop;
    @(negedge clock);
    if (wr_a && !fifo_out_full) begin
      q_a.push_back(din_a);
      q_b.push_back(din_b);
      q_c.push_back(din_c);
    end
    if (rd_b !== rd_a || rd_c !== rd_a || wr_b !== wr_a || wr_c !== wr_a) sync_err++;
    if (held_prev && (wr_a !== 1'b1 || din_a !== din_prev)) hold_violations++;
    held_prev = wr_a && fifo_out_full;
    din_prev  = din_a;
    do_pop    = rd_a;
    @(posedge clock);
    #1;
    if (do_pop) begin
      if (src_q.size() > 0) src_q.delete(0);
      rd_count++;
    end
    drive_inputs();
  endtask

  task automatic clear_capture();
    q_a.delete();
    q_b.delete();
    q_c.delete();
    rd_count  = 0;
    held_prev = 1'b0;
  endtask

  // Run until n_out outputs have been pushed, then idle to catch extras.
  task automatic run_until(input int n_out, input int budget, input int hold_at);
    int  cyc = 0;
    bit  hold_done = 1'b0;
    while (q_a.size() < n_out && cyc < budget) begin
      if (hold_at >= 0 && !hold_done && q_a.size() >= hold_at) begin
        hold_left = 20;
        hold_done = 1'b1;
      end
      step();
      cyc++;
    end
    checks++;
    if (q_a.size() < n_out) begin
      failures++;
      $display("FAIL run_timeout: outputs=%0d required=%0d", q_a.size(), n_out);
    end
    gap_pct   = 0;
    full_pct  = 0;
    hold_left = 0;
    repeat (W + 4) step();
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    fill_frame(0, 0);
    load_frame(0);
    drive_inputs();
    reset = 1'b1;
    repeat (3) step();
    @(negedge clock);
    checks++;
    if (rd_a !== 1'b0) begin
      failures++; $display("FAIL reset_rd_en: got=%b exp=0", rd_a);
    end
    checks++;
    if (wr_a !== 1'b0) begin
      failures++; $display("FAIL reset_wr_en: got=%b exp=0", wr_a);
    end
    checks++;
    if (din_a !== 8'h00) begin
      failures++; $display("FAIL reset_din: got=%0d exp=0", din_a);
    end
    checks++;
    if (dut_a.state !== S_FILL) begin
      failures++; $display("FAIL reset_state: got=%0d exp=%0d", dut_a.state, S_FILL);
    end
    checks++;
    if (rd_count !== 0) begin
      failures++; $display("FAIL reset_pops: got=%0d exp=0", rd_count);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_constant();
    clear_capture();
    run_until(N, 1000, -1);
    checks++;
    if (q_a.size() !== N) begin
      failures++; $display("FAIL const_count: got=%0d exp=%0d", q_a.size(), N);
    end
    checks++;
    if (rd_count !== N) begin
      failures++; $display("FAIL const_rd_count: got=%0d exp=%0d", rd_count, N);
    end
    for (int i = 0; i < N && i < q_a.size(); i++) begin
      checks++;
      if (q_a[i] !== 8'd0 || q_b[i] !== 8'd0 || q_c[i] !== 8'd0) begin
        failures++;
        $display("FAIL const_pix[%0d]: got=%0d/%0d/%0d exp=0", i, q_a[i], q_b[i], q_c[i]);
      end
    end
    checks++;
    if (dut_a.state !== S_FILL) begin
      failures++; $display("FAIL const_end_state: got=%0d exp=%0d", dut_a.state, S_FILL);
    end
  endtask

  task automatic test_step_edge();
    clear_capture();
    fill_frame(0, 1);
    load_frame(0);
    drive_inputs();
    run_until(N, 1000, -1);
    checks++;
    if (q_a.size() !== N) begin
      failures++; $display("FAIL step_count: got=%0d exp=%0d", q_a.size(), N);
    end
    for (int i = 0; i < N && i < q_a.size(); i++) begin
      int x = i % W;
      int y = i / W;
      logic [7:0] e = (y >= 1 && y <= 4 && (x == 3 || x == 4)) ? 8'd255 : 8'd0;
      checks++;
      if (q_a[i] !== e || q_b[i] !== e || q_c[i] !== e) begin
        failures++;
        $display("FAIL step_pix[%0d]: got=%0d/%0d/%0d exp=%0d", i, q_a[i], q_b[i], q_c[i], e);
      end
    end
  endtask

  task automatic test_ramp();
    clear_capture();
    fill_frame(0, 2);
    load_frame(0);
    drive_inputs();
    run_until(N, 1000, -1);
    checks++;
    if (q_a.size() !== N) begin
      failures++; $display("FAIL ramp_count: got=%0d exp=%0d", q_a.size(), N);
    end
    for (int i = 0; i < N && i < q_a.size(); i++) begin
      int x = i % W;
      int y = i / W;
      logic [7:0] e = (x > 0 && x < W - 1 && y > 0 && y < H - 1) ? 8'd80 : 8'd0;
      checks++;
      if (q_a[i] !== e || q_b[i] !== e || q_c[i] !== 8'd0) begin
        failures++;
        $display("FAIL ramp_pix[%0d]: got=%0d/%0d/%0d exp=%0d/%0d/0", i, q_a[i], q_b[i], q_c[i], e, e);
      end
    end
  endtask

  task automatic test_backpressure();
    clear_capture();
    hold_violations = 0;
    fill_frame(0, 3);
    load_frame(0);
    full_pct = 30;
    drive_inputs();
    run_until(N, 3000, 15);
    checks++;
    if (q_a.size() !== N) begin
      failures++; $display("FAIL bp_count: got=%0d exp=%0d", q_a.size(), N);
    end
    checks++;
    if (hold_violations !== 0) begin
      failures++; $display("FAIL bp_stable_while_full: got=%0d violations exp=0", hold_violations);
    end
    for (int i = 0; i < N && i < q_a.size(); i++) begin
      logic [7:0] ea = model(0, i % W, i / W, 0, 0);
      logic [7:0] eb = model(0, i % W, i / W, 1, 0);
      logic [7:0] ec = model(0, i % W, i / W, 0, 100);
      checks++;
      if (q_a[i] !== ea || q_b[i] !== eb || q_c[i] !== ec) begin
        failures++;
        $display("FAIL bp_pix[%0d]: got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                 i, q_a[i], q_b[i], q_c[i], ea, eb, ec);
      end
    end
  endtask

  task automatic test_starvation();
    clear_capture();
    fill_frame(0, 3);
    load_frame(0);
    gap_pct = 50;
    drive_inputs();
    run_until(N, 3000, -1);
    checks++;
    if (q_a.size() !== N || rd_count !== N) begin
      failures++;
      $display("FAIL starve_count: got=%0d out %0d reads exp=%0d", q_a.size(), rd_count, N);
    end
    for (int i = 0; i < N && i < q_a.size(); i++) begin
      logic [7:0] ea = model(0, i % W, i / W, 0, 0);
      logic [7:0] eb = model(0, i % W, i / W, 1, 0);
      logic [7:0] ec = model(0, i % W, i / W, 0, 100);
      checks++;
      if (q_a[i] !== ea || q_b[i] !== eb || q_c[i] !== ec) begin
        failures++;
        $display("FAIL starve_pix[%0d]: got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                 i, q_a[i], q_b[i], q_c[i], ea, eb, ec);
      end
    end
  endtask

  task automatic test_reset_back_to_back();
    int cyc = 0;
    clear_capture();
    fill_frame(0, 3);
    fill_frame(1, 3);
    load_frame(0);
    drive_inputs();
    while (rd_count < 20 && cyc < 500) begin
      step();
      cyc++;
    end
    checks++;
    if (rd_count < 20) begin
      failures++; $display("FAIL midreset_reads: got=%0d exp>=20", rd_count);
    end
    reset = 1'b1;
    repeat (2) step();
    src_q.delete();
    clear_capture();
    reset = 1'b0;
    load_frame(0);
    load_frame(1);
    drive_inputs();
    run_until(2 * N, 3000, -1);
    checks++;
    if (q_a.size() !== 2 * N) begin
      failures++; $display("FAIL b2b_count: got=%0d exp=%0d", q_a.size(), 2 * N);
    end
    for (int i = 0; i < 2 * N && i < q_a.size(); i++) begin
      int f = i / N;
      int p = i % N;
      logic [7:0] ea = model(f, p % W, p / W, 0, 0);
      logic [7:0] eb = model(f, p % W, p / W, 1, 0);
      logic [7:0] ec = model(f, p % W, p / W, 0, 100);
      checks++;
      if (q_a[i] !== ea || q_b[i] !== eb || q_c[i] !== ec) begin
        failures++;
        $display("FAIL b2b_pix[%0d]: got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                 i, q_a[i], q_b[i], q_c[i], ea, eb, ec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_step_edge();
    test_ramp();
    test_backpressure();
    test_starvation();
    test_reset_back_to_back();
    checks++;
    if (sync_err !== 0) begin
      failures++; $display("FAIL mode_handshake_sync: got=%0d differing cycles exp=0", sync_err);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
